// File: rtl/uart_rx_capture_if.sv
// Byte stream handshake between the UART capture FIFO and its consumer.
// The receiver is the master; the host-side collector is the slave.
interface uart_rx_capture_if;
   logic [7:0] data_o;
   logic       valid_o;
   logic       ready_i;

   modport master (output data_o, output valid_o, input ready_i);
   modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver for the SoC uart_tx pin, feeding a byte FIFO.
// Flags end-of-line, framing errors and FIFO overflow.
module uart_rx_capture #(
   parameter int          CLKS_PER_BIT = 32,
   parameter int          DEPTH        = 16,
   parameter logic [7:0]  EOL_CHAR     = 8'h0A,
   localparam int         AW           = $clog2(DEPTH),
   localparam int         LW           = AW + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_i,
   input  logic                 rx_en_i,
   input  logic                 clear_i,
   uart_rx_capture_if.master    stream,
   output logic [LW-1:0]        level_o,
   output logic                 eol_o,
   output logic                 frame_err_o,
   output logic                 overflow_o
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          rx_q1;
   logic          rx_s;
   logic          rx_prev;
   logic [1:0]    settle;

   logic [7:0]    mem [DEPTH];
   logic [LW-1:0] wptr;
   logic [LW-1:0] rptr;

   logic tick_done;
   logic fall;
   logic push;
   logic ferr;
   logic empty;
   logic full;
   logic pop;
   logic wr;
   logic drop;

   assign tick_done = (timer == '0);
   // Edges are only trusted once rx_prev holds a real line sample,
   // so a line already low at reset release never looks like a start.
   assign fall  = (settle == 2'd3) && rx_prev && !rx_s;
   assign push  = (state == S_STOP) && tick_done && rx_s;
   assign ferr  = (state == S_STOP) && tick_done && !rx_s;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop   = !empty && stream.ready_i;
   assign wr    = push && (!full || pop);
   assign drop  = push && full && !pop;

   assign stream.valid_o = !empty;
   assign stream.data_o  = empty ? 8'h00 : mem[rptr[AW-1:0]];
   assign level_o        = wptr - rptr;

   // Two-flop synchronizer plus edge history and post-reset settle count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
         settle  <= 2'd0;
      end else begin
         rx_q1   <= rx_i;
         rx_s    <= rx_q1;
         rx_prev <= rx_s;
         if (settle != 2'd3) settle <= settle + 2'd1;
      end
   end

   // Frame FSM: mid-bit sampling driven by a reloading down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         timer <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (fall && rx_en_i) begin
                  state <= S_START;
                  timer <= HALF;
               end
            end
            S_START: begin
               if (!tick_done) begin
                  timer <= timer - 1'b1;
               end else if (rx_s) begin
                  state <= S_IDLE;
                  timer <= HALF;
               end else begin
                  state <= S_DATA;
                  idx   <= '0;
                  timer <= FULL;
               end
            end
            S_DATA: begin
               if (!tick_done) begin
                  timer <= timer - 1'b1;
               end else begin
                  shreg[idx] <= rx_s;
                  timer      <= FULL;
                  if (idx == 3'd7) state <= S_STOP;
                  else             idx   <= idx + 3'd1;
               end
            end
            S_STOP: begin
               if (!tick_done) begin
                  timer <= timer - 1'b1;
               end else begin
                  state <= rx_s ? S_IDLE : S_BREAK;
                  timer <= HALF;
               end
            end
            S_BREAK: begin
               if (rx_s) begin
                  state <= S_IDLE;
                  timer <= HALF;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO storage; head is gated to zero when empty.
   always_ff @(posedge clk) begin
      if (wr) mem[wptr[AW-1:0]] <= shreg;
   end

   // FIFO pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr)  wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
      end
   end

   // Status flags: EOL pulse and sticky errors, where set beats clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eol_o       <= 1'b0;
         frame_err_o <= 1'b0;
         overflow_o  <= 1'b0;
      end else begin
         eol_o <= wr && (shreg == EOL_CHAR);
         if (ferr)         frame_err_o <= 1'b1;
         else if (clear_i) frame_err_o <= 1'b0;
         if (drop)         overflow_o  <= 1'b1;
         else if (clear_i) overflow_o  <= 1'b0;
      end
   end

endmodule
